// File: rtl/neurochip_pkg.sv
// Shared constants and the hex-to-7-segment encoder for the LIF neuron array.
package neurochip_pkg;

  localparam int unsigned N_NEURON = 4;
  localparam int unsigned N_IN     = 8;
  localparam int unsigned V_W      = 8;
  localparam int unsigned WEIGHT_W = 4;

  localparam logic [4:0] ADDR_THR  = 5'h10;
  localparam logic [4:0] ADDR_LEAK = 5'h14;
  localparam logic [4:0] ADDR_DISP = 5'h15;

  localparam logic [7:0] THR_RST  = 8'h10;
  localparam logic [2:0] LEAK_RST = 3'd3;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex7seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: leak, weighted sum of 8 inputs, clamp, threshold.
module lif_neuron
  import neurochip_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       step_i,
  input  logic [N_IN-1:0]            x_i,
  input  logic [N_IN*WEIGHT_W-1:0]   weights_i,
  input  logic [V_W-1:0]             thr_i,
  input  logic [2:0]                 leak_i,
  output logic [V_W-1:0]             v_o,
  output logic                       spike_o
);

  logic [V_W-1:0]        v_q, v_d;
  logic                  spike_q, spike_d;
  logic [V_W-1:0]        v_leaked;
  logic signed [10:0]    r;
  logic signed [WEIGHT_W-1:0] w;
  logic [V_W-1:0]        r_clamped;

  always_comb begin
    // leak=0 shifts by zero, so V-V removes the whole membrane potential
    v_leaked = v_q - (v_q >> leak_i);
    r        = signed'({3'b000, v_leaked});
    w        = '0;
    for (int i = 0; i < N_IN; i++) begin
      w = weights_i[i*WEIGHT_W +: WEIGHT_W];
      if (x_i[i]) r = r + 11'(w);
    end

    if (r < 0)              r_clamped = '0;
    else if (r > 11'sd255)  r_clamped = '1;
    else                    r_clamped = r[V_W-1:0];

    v_d     = v_q;
    spike_d = spike_q;
    if (step_i) begin
      if (r_clamped >= thr_i) begin
        spike_d = 1'b1;
        v_d     = '0;
      end else begin
        spike_d = 1'b0;
        v_d     = r_clamped;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

  assign v_o     = v_q;
  assign spike_o = spike_q;

endmodule

// File: rtl/retospect_neurochip.sv
// Four recurrently wired LIF neurons with a byte-wide config register file and 7-seg readout.
module retospect_neurochip
  import neurochip_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0]     w_q [16];
  logic [7:0]     thr_q [N_NEURON];
  logic [2:0]     leak_q;
  logic [2:0]     disp_q;
  logic [V_W-1:0] v [N_NEURON];
  logic [N_NEURON-1:0] spike;

  logic       cfg_we, wr_en, step_en;
  logic [4:0] cfg_addr;
  logic       unused_uio;

  assign cfg_we     = uio_in[7];
  assign cfg_addr   = uio_in[4:0];
  assign unused_uio = ^uio_in[6:5];
  assign wr_en      = ena & cfg_we;
  assign step_en    = ena & ~cfg_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      for (int n = 0; n < N_NEURON; n++) thr_q[n] <= THR_RST;
      leak_q <= LEAK_RST;
      disp_q <= '0;
    end else if (wr_en) begin
      if (!cfg_addr[4]) begin
        w_q[cfg_addr[3:0]] <= ui_in;
      end else if (cfg_addr[4:2] == ADDR_THR[4:2]) begin
        thr_q[cfg_addr[1:0]] <= ui_in;
      end else if (cfg_addr == ADDR_LEAK) begin
        leak_q <= ui_in[2:0];
      end else if (cfg_addr == ADDR_DISP) begin
        disp_q <= ui_in[2:0];
      end
    end
  end

  // Byte 4n+p carries weights for inputs 2p (low nibble) and 2p+1 (high nibble) of neuron n.
  for (genvar n = 0; n < N_NEURON; n++) begin : g_neuron
    lif_neuron u_neuron (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .step_i    (step_en),
      .x_i       ({spike, ui_in[3:0]}),
      .weights_i ({w_q[4*n+3], w_q[4*n+2], w_q[4*n+1], w_q[4*n]}),
      .thr_i     (thr_q[n]),
      .leak_i    (leak_q),
      .v_o       (v[n]),
      .spike_o   (spike[n])
    );
  end

  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg;

  always_comb begin
    digit = '0;
    blank = 1'b0;
    case (disp_q)
      3'd0:                   digit = spike;
      3'd1, 3'd2, 3'd3, 3'd4: digit = v[disp_q[1:0] - 2'd1][7:4];
      default:                blank = 1'b1;
    endcase
    seg = blank ? 7'h00 : hex7seg(digit);
  end

  assign uo_out  = {|spike, seg};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_retospect_neurochip.sv
// Directed bench with a behavioural reference model feeding an expected-output scoreboard.
module tb_retospect_neurochip;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  retospect_neurochip dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb_q[$];

  logic [7:0] mw [16];
  logic [7:0] mthr [4];
  int         mleak, mdisp;
  int         mv [4];
  logic [3:0] msp;
  logic [6:0] seg_tab [16];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) mw[i] = 8'h00;
    for (int n = 0; n < 4; n++) begin
      mthr[n] = 8'h10;
      mv[n]   = 0;
    end
    mleak = 3;
    mdisp = 0;
    msp   = 4'h0;
  endtask

  function automatic logic [7:0] m_uo();
    logic [6:0] s;
    if (mdisp == 0)      s = seg_tab[msp];
    else if (mdisp <= 4) s = seg_tab[mv[mdisp-1] / 16];
    else                 s = 7'h00;
    return {|msp, s};
  endfunction

  task automatic m_edge(input logic [7:0] ui, input logic [7:0] uio, input logic en);
    int a, r, nib;
    logic [7:0] x, b;
    logic [3:0] nsp;
    if (!en) return;
    if (uio[7]) begin
      a = int'(uio[4:0]);
      if (a < 16)       mw[a] = ui;
      else if (a < 20)  mthr[a-16] = ui;
      else if (a == 20) mleak = int'(ui[2:0]);
      else if (a == 21) mdisp = int'(ui[2:0]);
    end else begin
      x = {msp, ui[3:0]};
      for (int n = 0; n < 4; n++) begin
        r = mv[n] - (mv[n] >> mleak);
        for (int i = 0; i < 8; i++) begin
          if (x[i]) begin
            b   = mw[n*4 + i/2];
            nib = (i % 2 == 1) ? int'(b[7:4]) : int'(b[3:0]);
            r   = r + ((nib > 7) ? nib - 16 : nib);
          end
        end
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        if (r >= int'(mthr[n])) begin
          nsp[n] = 1'b1;
          mv[n]  = 0;
        end else begin
          nsp[n] = 1'b0;
          mv[n]  = r;
        end
      end
      msp = nsp;
    end
  endtask

  task automatic step(input logic [7:0] ui, input logic [7:0] uio, input logic en,
                      input string tag);
    logic [7:0] exp;
    ui_in  = ui;
    uio_in = uio;
    ena    = en;
    m_edge(ui, uio, en);
    sb_q.push_back(m_uo());
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check(tag, uo_out, exp);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [7:0] data);
    step(data, {3'b100, addr}, 1'b1, "cfg_write");
  endtask

  task automatic run(input logic [7:0] ui, input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) step(ui, 8'h00, 1'b1, tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_reset();
    #2;
    check({tag, "_uo"}, uo_out, 8'h3F);
    check({tag, "_uio_oe"}, uio_oe, 8'h00);
    check({tag, "_uio_out"}, uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
    seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;
    ena = 1'b1;

    do_reset("reset");

    // Integrate and fire on the third edge.
    wr(5'h00, 8'h07);
    wr(5'h14, 8'h07);
    run(8'h01, 3, "integrate");
    check("fire_n0", uo_out, 8'h86);

    // Negative weight clamps at zero.
    do_reset("reset2");
    wr(5'h00, 8'h08);
    wr(5'h15, 8'h01);
    run(8'h01, 5, "neg_clamp");
    check("neg_clamp_v0", uo_out, 8'h3F);

    // Recurrent spike from neuron 0 drives neuron 1 one cycle later.
    do_reset("reset3");
    wr(5'h00, 8'h07);
    wr(5'h14, 8'h07);
    wr(5'h06, 8'h07);
    wr(5'h11, 8'h05);
    run(8'h01, 3, "recur_a");
    check("recur_n0", uo_out, 8'h86);
    run(8'h01, 1, "recur_b");
    check("recur_n1", uo_out, 8'hDB);

    // Long integration with no leak reaches 112.
    do_reset("reset4");
    wr(5'h00, 8'h07);
    wr(5'h10, 8'hFF);
    wr(5'h14, 8'h07);
    wr(5'h15, 8'h01);
    run(8'h01, 16, "leak7");
    check("leak7_v0", uo_out, 8'h07);
    wr(5'h15, 8'h05);
    check("disp_blank", uo_out, 8'h00);

    // Leak of 1 settles at 14.
    do_reset("reset5");
    wr(5'h00, 8'h07);
    wr(5'h10, 8'hFF);
    wr(5'h14, 8'h01);
    wr(5'h15, 8'h01);
    run(8'h01, 16, "leak1");
    check("leak1_v0", uo_out, 8'h3F);

    // Freeze via ena=0 and via cfg_we=1; a write while disabled must be dropped.
    do_reset("reset6");
    wr(5'h00, 8'h07);
    wr(5'h10, 8'hFF);
    wr(5'h14, 8'h07);
    wr(5'h15, 8'h01);
    run(8'h01, 3, "pre_freeze");
    check("pre_freeze_v0", uo_out, 8'h06);
    for (int k = 0; k < 3; k++) step(8'h0F, 8'h00, 1'b0, "freeze_ena");
    step(8'h0F, 8'h96, 1'b1, "freeze_we");
    step(8'h00, 8'h90, 1'b0, "dropped_write");
    check("frozen_v0", uo_out, 8'h06);
    run(8'h01, 1, "post_freeze");
    check("thr_kept", uo_out, 8'h06);
    run(8'h01, 2, "post_freeze2");
    check("post_freeze_v0", uo_out, 8'h5B);

    // Asynchronous reset mid-run.
    do_reset("reset_mid");
    run(8'h0F, 2, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
